// File: rtl/tristate_driver_if.sv
// Control and status bundle for tristate_driver.
// The tristate bus pin itself is a plain net port on the driver.
interface tristate_driver_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] data_in;
    logic             data_en;
    logic [WIDTH-1:0] lane_mask;
    logic             driving;
    logic             en_rise;
    logic [CNT_W-1:0] drive_cycles;

    modport master (
        output data_in,
        output data_en,
        output lane_mask,
        input  driving,
        input  en_rise,
        input  drive_cycles
    );

    modport slave (
        input  data_in,
        input  data_en,
        input  lane_mask,
        output driving,
        output en_rise,
        output drive_cycles
    );
endinterface

// File: rtl/tristate_driver.sv
// WIDTH-bit tristate bus driver with per-lane mask, optional registered
// stage and drive-activity status (enable-rise pulse, saturating counter).
module tristate_driver #(
    parameter int WIDTH      = 8,
    parameter bit REGISTERED = 1'b0,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    tristate_driver_if.slave bus,
    output tri   [WIDTH-1:0] data_out
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             r_en_q;
    logic [WIDTH-1:0] r_data_q;
    logic             r_en_prev;
    logic             r_en_rise;
    logic [CNT_W-1:0] r_cnt;

    logic             w_eff_en;
    logic [WIDTH-1:0] w_src;
    logic [WIDTH-1:0] w_lane_en;
    logic             w_driving;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_en_q   <= 1'b0;
            r_data_q <= '0;
        end else begin
            r_en_q   <= bus.data_en;
            r_data_q <= bus.data_in;
        end
    end

    // Unregistered mode gates enable on the rst level so the bus drops at once
    assign w_eff_en  = REGISTERED ? r_en_q : (bus.data_en & ~rst);
    assign w_src     = REGISTERED ? r_data_q : bus.data_in;
    assign w_lane_en = {WIDTH{w_eff_en}} & bus.lane_mask;
    assign w_driving = |w_lane_en;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        assign data_out[i] = w_lane_en[i] ? w_src[i] : 1'bz;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_en_prev <= 1'b0;
            r_en_rise <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_en_prev <= w_eff_en;
            r_en_rise <= w_eff_en & ~r_en_prev;
            if (w_driving && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.driving      = w_driving;
    assign bus.en_rise      = r_en_rise;
    assign bus.drive_cycles = r_cnt;
endmodule

// File: tb/tb_tristate_driver.sv
// Self-checking bench: combinational driver with 4-bit counter (A) and
// registered driver with 16-bit counter (B) against a behavioural model.
module tb_tristate_driver;
    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    tristate_driver_if #(.WIDTH(8), .CNT_W(4))  ifa ();
    tristate_driver_if #(.WIDTH(8), .CNT_W(16)) ifb ();

    tri   [7:0] w_bus_a;
    tri   [7:0] w_bus_b;
    logic [7:0] w_z_a;
    logic [7:0] w_z_b;

    tristate_driver #(.WIDTH(8), .REGISTERED(1'b0), .CNT_W(4)) u_a (
        .clk      (clk),
        .rst      (rst_a),
        .bus      (ifa),
        .data_out (w_bus_a)
    );

    tristate_driver #(.WIDTH(8), .REGISTERED(1'b1), .CNT_W(16)) u_b (
        .clk      (clk),
        .rst      (rst_b),
        .bus      (ifb),
        .data_out (w_bus_b)
    );

    for (genvar g = 0; g < 8; g++) begin : g_z
        assign w_z_a[g] = (w_bus_a[g] === 1'bz);
        assign w_z_b[g] = (w_bus_b[g] === 1'bz);
    end

    // Behavioural model: edge history as plain counters
    int   ma_cnt;
    bit   ma_prev;
    bit   ma_rise;
    int   mb_cnt;
    bit   mb_prev;
    bit   mb_rise;
    bit   mb_en_q;
    logic [7:0] mb_dq;

    always @(posedge clk) begin : model_a
        bit e;
        e = ifa.data_en && !rst_a;
        if (rst_a) begin
            ma_cnt  = 0;
            ma_prev = 1'b0;
            ma_rise = 1'b0;
        end else begin
            ma_rise = e && !ma_prev;
            ma_prev = e;
            if (e && ifa.lane_mask != 8'h00 && ma_cnt < 15) ma_cnt++;
        end
    end

    always @(posedge clk) begin : model_b
        bit e;
        e = mb_en_q;
        if (rst_b) begin
            mb_cnt  = 0;
            mb_prev = 1'b0;
            mb_rise = 1'b0;
            mb_en_q = 1'b0;
            mb_dq   = 8'h00;
        end else begin
            mb_rise = e && !mb_prev;
            mb_prev = e;
            if (e && ifb.lane_mask != 8'h00 && mb_cnt < 65535) mb_cnt++;
            mb_en_q = ifb.data_en;
            mb_dq   = ifb.data_in;
        end
    end

    task automatic cmp(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_a(input string nm);
        logic [7:0] m;
        logic [7:0] ez;
        logic [7:0] ed;
        logic [7:0] ad;
        logic [3:0] ec;
        m  = (ifa.data_en && !rst_a) ? ifa.lane_mask : 8'h00;
        ez = ~m;
        ed = ifa.data_in & m;
        ad = w_bus_a & m;
        ec = 4'(ma_cnt);
        cmp({nm, ".a.z"},    {24'h0, w_z_a}, {24'h0, ez});
        cmp({nm, ".a.data"}, {24'h0, ad},    {24'h0, ed});
        cmp({nm, ".a.drv"},  {31'h0, ifa.driving}, {31'h0, (m != 8'h00)});
        cmp({nm, ".a.rise"}, {31'h0, ifa.en_rise}, {31'h0, ma_rise});
        cmp({nm, ".a.cnt"},  {28'h0, ifa.drive_cycles}, {28'h0, ec});
    endtask

    task automatic chk_b(input string nm);
        logic [7:0]  m;
        logic [7:0]  ez;
        logic [7:0]  ed;
        logic [7:0]  ad;
        logic [15:0] ec;
        m  = mb_en_q ? ifb.lane_mask : 8'h00;
        ez = ~m;
        ed = mb_dq & m;
        ad = w_bus_b & m;
        ec = 16'(mb_cnt);
        cmp({nm, ".b.z"},    {24'h0, w_z_b}, {24'h0, ez});
        cmp({nm, ".b.data"}, {24'h0, ad},    {24'h0, ed});
        cmp({nm, ".b.drv"},  {31'h0, ifb.driving}, {31'h0, (m != 8'h00)});
        cmp({nm, ".b.rise"}, {31'h0, ifb.en_rise}, {31'h0, mb_rise});
        cmp({nm, ".b.cnt"},  {16'h0, ifb.drive_cycles}, {16'h0, ec});
    endtask

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] din;
        logic [7:0] mask;
        logic [7:0] exp_z;
        logic [7:0] exp_d;
        logic       exp_drv;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int rises;
        logic [7:0] rm;
        bit tog[6];

        tbl[0]  = '{1'b0, 1'b0, 8'hAA, 8'hFF, 8'hFF, 8'h00, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 8'hAA, 8'hFF, 8'h00, 8'hAA, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 8'hCC, 8'hFF, 8'h00, 8'hCC, 1'b1};
        tbl[3]  = '{1'b0, 1'b0, 8'hCC, 8'hFF, 8'hFF, 8'h00, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 8'hFF, 8'h0F, 8'hF0, 8'h0F, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 8'hFF, 8'h00, 8'hFF, 8'h00, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 8'h5A, 8'hF0, 8'h0F, 8'h50, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 8'hAA, 8'hFF, 8'hFF, 8'h00, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 8'hAA, 8'hFF, 8'hFF, 8'h00, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 8'hAA, 8'hFF, 8'h00, 8'hAA, 1'b1};
        tbl[10] = '{1'b0, 1'b1, 8'hAA, 8'hFF, 8'h00, 8'hAA, 1'b1};

        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.data_en = 1'b0; ifa.data_in = 8'h00; ifa.lane_mask = 8'hFF;
        ifb.data_en = 1'b0; ifb.data_in = 8'h00; ifb.lane_mask = 8'hFF;
        repeat (2) @(negedge clk);
        #1;
        chk_a("reset");
        chk_b("reset");
        cmp("reset.a.cnt0", {28'h0, ifa.drive_cycles}, 32'h0);

        // Table vectors on A: combinational path, mask and rst gating
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            rst_a = tbl[i].rst;
            ifa.data_en = tbl[i].en;
            ifa.data_in = tbl[i].din;
            ifa.lane_mask = tbl[i].mask;
            #1;
            cmp($sformatf("tbl%0d.z", i), {24'h0, w_z_a}, {24'h0, tbl[i].exp_z});
            cmp($sformatf("tbl%0d.d", i), {24'h0, w_bus_a & ~tbl[i].exp_z},
                {24'h0, tbl[i].exp_d});
            cmp($sformatf("tbl%0d.drv", i), {31'h0, ifa.driving},
                {31'h0, tbl[i].exp_drv});
            chk_a($sformatf("tbl%0d", i));
        end

        // A: en_rise after reset release is a single pulse
        @(negedge clk); #1;
        cmp("rise.once", {31'h0, ifa.en_rise}, 32'h0);

        // A: counter saturation at 15, hold, clear
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0; ifa.data_en = 1'b1; ifa.lane_mask = 8'hFF;
        repeat (20) @(negedge clk);
        #1;
        cmp("sat.15", {28'h0, ifa.drive_cycles}, 32'd15);
        chk_a("sat");
        ifa.data_en = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        cmp("sat.hold", {28'h0, ifa.drive_cycles}, 32'd15);
        rst_a = 1'b1;
        @(negedge clk); #1;
        cmp("sat.clr", {28'h0, ifa.drive_cycles}, 32'd0);
        chk_a("sat.clr");

        // A: enable toggling 0,1,0,1,1,1 gives two rises, four edges
        rst_a = 1'b0;
        tog = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        rises = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ifa.en_rise) rises++;
            ifa.data_en = tog[k];
        end
        @(negedge clk);
        if (ifa.en_rise) rises++;
        ifa.data_en = 1'b0;
        #1;
        cmp("tog.rises", rises, 32'd2);
        cmp("tog.cnt", {28'h0, ifa.drive_cycles}, 32'd4);

        // B: one-edge latency on data and enable
        rst_b = 1'b0;
        @(negedge clk);
        ifb.data_en = 1'b1; ifb.data_in = 8'h55; ifb.lane_mask = 8'hFF;
        #1;
        cmp("reg.pre", {24'h0, w_z_b}, 32'hFF);
        chk_b("reg.pre");
        @(posedge clk); #1;
        cmp("reg.55z", {24'h0, w_z_b}, 32'h00);
        cmp("reg.55", {24'h0, w_bus_b}, 32'h55);
        @(negedge clk);
        ifb.data_in = 8'hCC;
        #1;
        cmp("reg.cc.pre", {24'h0, w_bus_b}, 32'h55);
        @(posedge clk); #1;
        cmp("reg.cc", {24'h0, w_bus_b}, 32'hCC);
        chk_b("reg.cc");
        @(negedge clk);
        ifb.data_en = 1'b0;
        #1;
        cmp("reg.off.pre", {24'h0, w_bus_b}, 32'hCC);
        @(posedge clk); #1;
        cmp("reg.off", {24'h0, w_z_b}, 32'hFF);
        chk_b("reg.off");

        // Randomized traffic on both instances
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            rst_a = ($urandom_range(0, 15) == 0);
            rst_b = ($urandom_range(0, 15) == 0);
            ifa.data_en = 1'($urandom);
            ifb.data_en = 1'($urandom);
            ifa.data_in = 8'($urandom);
            ifb.data_in = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       rm = 8'h00;
                1:       rm = 8'hFF;
                default: rm = 8'($urandom);
            endcase
            ifa.lane_mask = rm;
            ifb.lane_mask = (rm == 8'h00) ? 8'($urandom) : rm;
            #1;
            chk_a($sformatf("rnd%0d", n));
            chk_b($sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
